tlb_lookup: RTL and testbench

TLB_LOOKUP -- requirements
Module: tlb_lookup

---
 rtl/tlb_lookup.sv | 180 ++++++++++++++++++
 tb/tb_tlb_lookup.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_lookup.sv
// Fully associative joint-pair TLB with a one-cycle registered lookup and a
// serial invalidation sweep that visits one entry per cycle.
module tlb_lookup #(
  parameter int NENTRY = 8,
  localparam int IW = (NENTRY > 1) ? $clog2(NENTRY) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          lkp_valid,
  output logic          lkp_ready,
  input  logic [18:0]   lkp_vpn2,
  input  logic          lkp_odd,
  input  logic [9:0]    lkp_asid,
  output logic          rsp_valid,
  output logic          rsp_hit,
  output logic [19:0]   rsp_pfn,
  output logic [1:0]    rsp_mat,
  output logic [1:0]    rsp_plv,
  output logic          rsp_v,
  output logic          rsp_d,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [18:0]   wr_vpn2,
  input  logic [9:0]    wr_asid,
  input  logic          wr_g,
  input  logic          wr_e,
  input  logic [25:0]   wr_lo0,
  input  logic [25:0]   wr_lo1,
  input  logic          inv_req,
  input  logic [1:0]    inv_op,
  input  logic [9:0]    inv_asid,
  input  logic [18:0]   inv_vpn2,
  output logic          inv_busy
);

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   sidx_q, sidx_d;
  logic [1:0]      op_q;
  logic [9:0]      kasid_q;
  logic [18:0]     kvpn_q;

  logic [NENTRY-1:0] e_q;
  logic [18:0]       vpn2_q [NENTRY];
  logic [9:0]        asid_q [NENTRY];
  logic [NENTRY-1:0] g_q;
  logic [25:0]       lo0_q  [NENTRY];
  logic [25:0]       lo1_q  [NENTRY];

  logic              rsp_valid_q, rsp_hit_q;
  logic [25:0]       rsp_lo_q;

  logic              inv_start, wr_fire, lkp_fire, sweep_clr, sweep_last;
  logic [NENTRY-1:0] match;
  logic              hit_any;
  logic [IW-1:0]     hit_idx;
  logic [25:0]       lo_d;

  assign inv_busy   = (state_q == SWEEP);
  assign lkp_ready  = ~inv_busy;
  assign lkp_fire   = lkp_valid & lkp_ready;
  assign wr_fire    = wr_en & ~inv_busy;
  assign inv_start  = (state_q == IDLE) & inv_req;
  assign sweep_last = (sidx_q == IW'(NENTRY - 1));

  always_comb begin
    state_d = state_q;
    sidx_d  = sidx_q;
    unique case (state_q)
      IDLE: begin
        if (inv_req) begin
          state_d = SWEEP;
          sidx_d  = '0;
        end
      end
      SWEEP: begin
        sidx_d = sidx_q + 1'b1;
        if (sweep_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sweep_clr = 1'b0;
    if (state_q == SWEEP) begin
      unique case (op_q)
        2'd0: sweep_clr = 1'b1;
        2'd1: sweep_clr = g_q[sidx_q];
        2'd2: sweep_clr = ~g_q[sidx_q] && (asid_q[sidx_q] == kasid_q);
        2'd3: sweep_clr = ~g_q[sidx_q] && (asid_q[sidx_q] == kasid_q) &&
                          (vpn2_q[sidx_q] == kvpn_q);
        default: sweep_clr = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sidx_q  <= '0;
      op_q    <= '0;
      kasid_q <= '0;
      kvpn_q  <= '0;
    end else begin
      state_q <= state_d;
      sidx_q  <= sidx_d;
      if (inv_start) begin
        op_q    <= inv_op;
        kasid_q <= inv_asid;
        kvpn_q  <= inv_vpn2;
      end
    end
  end

  // Writes are blocked while sweeping, so the two updates never target e_q together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q <= '0;
    end else begin
      if (wr_fire) e_q[wr_idx] <= wr_e;
      if (sweep_clr) e_q[sidx_q] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      vpn2_q[wr_idx] <= wr_vpn2;
      asid_q[wr_idx] <= wr_asid;
      g_q[wr_idx]    <= wr_g;
      lo0_q[wr_idx]  <= wr_lo0;
      lo1_q[wr_idx]  <= wr_lo1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NENTRY; i++) begin
      match[i] = e_q[i] && (vpn2_q[i] == lkp_vpn2) &&
                 (g_q[i] || (asid_q[i] == lkp_asid));
    end
  end

  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NENTRY; i++) begin
      if (match[i] && !hit_any) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    lo_d = '0;
    if (hit_any) lo_d = lkp_odd ? lo1_q[hit_idx] : lo0_q[hit_idx];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_lo_q    <= '0;
    end else begin
      rsp_valid_q <= lkp_fire;
      rsp_hit_q   <= lkp_fire & hit_any;
      rsp_lo_q    <= lkp_fire ? lo_d : '0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_pfn   = rsp_lo_q[25:6];
  assign rsp_plv   = rsp_lo_q[5:4];
  assign rsp_mat   = rsp_lo_q[3:2];
  assign rsp_d     = rsp_lo_q[1];
  assign rsp_v     = rsp_lo_q[0];

endmodule

// File: tb/tb_tlb_lookup.sv
// Directed table-driven bench for tlb_lookup plus hand sequences for the
// invalidation sweep and asynchronous reset.
module tb_tlb_lookup;

  logic        clk = 1'b0;
  logic        resetn;
  logic        lkp_valid, lkp_ready, lkp_odd;
  logic [18:0] lkp_vpn2;
  logic [9:0]  lkp_asid;
  logic        rsp_valid, rsp_hit, rsp_v, rsp_d;
  logic [19:0] rsp_pfn;
  logic [1:0]  rsp_mat, rsp_plv;
  logic        wr_en, wr_g, wr_e;
  logic [2:0]  wr_idx;
  logic [18:0] wr_vpn2;
  logic [9:0]  wr_asid;
  logic [25:0] wr_lo0, wr_lo1;
  logic        inv_req, inv_busy;
  logic [1:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_vpn2;

  int n_checks = 0;
  int n_fail   = 0;

  tlb_lookup #(.NENTRY(8)) dut (
    .clk(clk), .resetn(resetn),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_vpn2(lkp_vpn2),
    .lkp_odd(lkp_odd), .lkp_asid(lkp_asid),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_pfn(rsp_pfn),
    .rsp_mat(rsp_mat), .rsp_plv(rsp_plv), .rsp_v(rsp_v), .rsp_d(rsp_d),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_vpn2(wr_vpn2), .wr_asid(wr_asid),
    .wr_g(wr_g), .wr_e(wr_e), .wr_lo0(wr_lo0), .wr_lo1(wr_lo1),
    .inv_req(inv_req), .inv_op(inv_op), .inv_asid(inv_asid),
    .inv_vpn2(inv_vpn2), .inv_busy(inv_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  idx;
    logic [18:0] vpn2;
    logic [9:0]  asid;
    logic        g, e;
    logic [25:0] lo0, lo1;
    logic        lkp;
    logic [18:0] lvpn;
    logic        lodd;
    logic [9:0]  lasid;
    logic        xhit;
    logic [25:0] xlo;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [25:0] mk(input logic [19:0] pfn, input logic [1:0] plv,
                                     input logic [1:0] mat, input logic d, input logic v);
    return {pfn, plv, mat, d, v};
  endfunction

  function automatic vec_t mkv(input logic wr, input logic [2:0] idx, input logic [18:0] vpn2,
                               input logic [9:0] asid, input logic g, input logic e,
                               input logic [25:0] lo0, input logic [25:0] lo1,
                               input logic lkp, input logic [18:0] lvpn, input logic lodd,
                               input logic [9:0] lasid, input logic xhit, input logic [25:0] xlo);
    vec_t r;
    r.wr = wr; r.idx = idx; r.vpn2 = vpn2; r.asid = asid; r.g = g; r.e = e;
    r.lo0 = lo0; r.lo1 = lo1; r.lkp = lkp; r.lvpn = lvpn; r.lodd = lodd;
    r.lasid = lasid; r.xhit = xhit; r.xlo = xlo;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] rsp_bus();
    return {rsp_valid, rsp_hit, rsp_pfn, rsp_plv, rsp_mat, rsp_d, rsp_v};
  endfunction

  task automatic wr(input logic [2:0] idx, input logic [18:0] vpn2, input logic [9:0] asid,
                    input logic g, input logic e, input logic [25:0] lo0, input logic [25:0] lo1);
    @(negedge clk);
    wr_en = 1'b1; wr_idx = idx; wr_vpn2 = vpn2; wr_asid = asid;
    wr_g = g; wr_e = e; wr_lo0 = lo0; wr_lo1 = lo1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic look(input string name, input logic [18:0] vpn2, input logic odd,
                      input logic [9:0] asid, input logic xhit, input logic [25:0] xlo);
    @(negedge clk);
    lkp_valid = 1'b1; lkp_vpn2 = vpn2; lkp_odd = odd; lkp_asid = asid;
    @(posedge clk); #1;
    chk(name, 64'(rsp_bus()), 64'({1'b1, xhit, xlo}));
    lkp_valid = 1'b0;
  endtask

  logic [18:0] tvpn  [8];
  logic [9:0]  tasid [8];
  logic [25:0] tlo1  [8];
  logic        texp  [8];
  int          busy_cnt;

  localparam logic [25:0] LO_A0 = 26'({20'h11111, 2'd2, 2'd2, 1'b1, 1'b1});
  localparam logic [25:0] LO_A1 = 26'({20'hABCDE, 2'd0, 2'd1, 1'b0, 1'b1});
  localparam logic [25:0] LO_B0 = 26'({20'h22222, 2'd1, 2'd0, 1'b1, 1'b1});
  localparam logic [25:0] LO_B1 = 26'({20'h33333, 2'd3, 2'd3, 1'b0, 1'b0});
  localparam logic [25:0] LO_C0 = 26'({20'h44444, 2'd0, 2'd0, 1'b0, 1'b1});
  localparam logic [25:0] LO_C1 = 26'({20'h55555, 2'd0, 2'd0, 1'b0, 1'b1});
  localparam logic [25:0] LO_D0 = 26'({20'h66666, 2'd0, 2'd3, 1'b1, 1'b1});
  localparam logic [25:0] LO_E0 = 26'({20'h77777, 2'd1, 2'd1, 1'b1, 1'b1});

  initial begin
    resetn = 1'b0;
    lkp_valid = 1'b0; lkp_vpn2 = '0; lkp_odd = 1'b0; lkp_asid = '0;
    wr_en = 1'b0; wr_idx = '0; wr_vpn2 = '0; wr_asid = '0; wr_g = 1'b0; wr_e = 1'b0;
    wr_lo0 = '0; wr_lo1 = '0;
    inv_req = 1'b0; inv_op = '0; inv_asid = '0; inv_vpn2 = '0;

    //            wr idx vpn2     asid g  e  lo0    lo1    lkp lvpn     odd lasid hit lo
    vecs[0]  = mkv(1, 2, 19'h10, 5, 0, 1, LO_A0, LO_A1, 0, 19'h0,  0, 0, 0, '0);
    vecs[1]  = mkv(0, 0, 19'h0,  0, 0, 0, '0,    '0,    1, 19'h10, 1, 5, 1, LO_A1);
    vecs[2]  = mkv(0, 0, 19'h0,  0, 0, 0, '0,    '0,    1, 19'h10, 0, 5, 1, LO_A0);
    vecs[3]  = mkv(0, 0, 19'h0,  0, 0, 0, '0,    '0,    1, 19'h11, 1, 5, 0, '0);
    vecs[4]  = mkv(0, 0, 19'h0,  0, 0, 0, '0,    '0,    1, 19'h10, 1, 6, 0, '0);
    vecs[5]  = mkv(1, 2, 19'h10, 5, 1, 1, LO_A0, LO_A1, 0, 19'h0,  0, 0, 0, '0);
    vecs[6]  = mkv(0, 0, 19'h0,  0, 0, 0, '0,    '0,    1, 19'h10, 1, 6, 1, LO_A1);
    vecs[7]  = mkv(1, 1, 19'h20, 1, 1, 1, LO_B0, LO_B1, 0, 19'h0,  0, 0, 0, '0);
    vecs[8]  = mkv(1, 4, 19'h20, 1, 1, 1, LO_C0, LO_C1, 0, 19'h0,  0, 0, 0, '0);
    vecs[9]  = mkv(0, 0, 19'h0,  0, 0, 0, '0,    '0,    1, 19'h20, 0, 9, 1, LO_B0);
    vecs[10] = mkv(0, 0, 19'h0,  0, 0, 0, '0,    '0,    1, 19'h20, 1, 9, 1, LO_B1);
    vecs[11] = mkv(1, 0, 19'h30, 2, 0, 1, LO_D0, '0,    1, 19'h30, 0, 2, 0, '0);
    vecs[12] = mkv(0, 0, 19'h0,  0, 0, 0, '0,    '0,    1, 19'h30, 0, 2, 1, LO_D0);
    vecs[13] = mkv(1, 5, 19'h40, 0, 1, 0, LO_E0, '0,    0, 19'h0,  0, 0, 0, '0);
    vecs[14] = mkv(0, 0, 19'h0,  0, 0, 0, '0,    '0,    1, 19'h40, 0, 0, 0, '0);
    vecs[15] = mkv(0, 0, 19'h0,  0, 0, 0, '0,    '0,    0, 19'h0,  0, 0, 0, '0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp", 64'(rsp_bus()), 64'd0);
    chk("reset_busy_ready", 64'({inv_busy, lkp_ready}), 64'b01);
    @(negedge clk);
    resetn = 1'b1;

    look("post_reset_miss", 19'h0, 0, 0, 0, '0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wr_en = vecs[i].wr; wr_idx = vecs[i].idx; wr_vpn2 = vecs[i].vpn2;
      wr_asid = vecs[i].asid; wr_g = vecs[i].g; wr_e = vecs[i].e;
      wr_lo0 = vecs[i].lo0; wr_lo1 = vecs[i].lo1;
      lkp_valid = vecs[i].lkp; lkp_vpn2 = vecs[i].lvpn; lkp_odd = vecs[i].lodd;
      lkp_asid = vecs[i].lasid;
      @(posedge clk); #1;
      if (vecs[i].lkp)
        chk($sformatf("vec%0d", i), 64'(rsp_bus()), 64'({1'b1, vecs[i].xhit, vecs[i].xlo}));
      else
        chk($sformatf("vec%0d_novalid", i), 64'(rsp_valid), 64'd0);
    end
    @(negedge clk);
    wr_en = 1'b0; lkp_valid = 1'b0;

    // Fill all entries: ASID 3 for idx 0..3, ASID 7 for 4..7, G=1 on idx 0,3,6.
    for (int i = 0; i < 8; i++) begin
      tvpn[i]  = 19'(32'h100 + i);
      tasid[i] = (i < 4) ? 10'd3 : 10'd7;
      tlo1[i]  = mk(20'(32'h50000 + i), 2'd0, 2'd0, 1'b0, 1'b1);
      wr(3'(i), tvpn[i], tasid[i], (i % 3) == 0, 1'b1, '0, tlo1[i]);
    end

    // Sweep start coincides with a write to idx 5 and a lookup of idx 7.
    @(negedge clk);
    inv_req = 1'b1; inv_op = 2'd2; inv_asid = 10'd3; inv_vpn2 = '0;
    wr_en = 1'b1; wr_idx = 3'd5; wr_vpn2 = 19'h300; wr_asid = 10'd7; wr_g = 1'b0;
    wr_e = 1'b1; wr_lo0 = '0; wr_lo1 = mk(20'h60005, 2'd2, 2'd1, 1'b1, 1'b1);
    lkp_valid = 1'b1; lkp_vpn2 = tvpn[7]; lkp_odd = 1'b1; lkp_asid = 10'd7;
    @(posedge clk); #1;
    chk("sweep_start_busy_ready", 64'({inv_busy, lkp_ready}), 64'b10);
    chk("inflight_rsp", 64'(rsp_bus()), 64'({1'b1, 1'b1, tlo1[7]}));
    tvpn[5] = 19'h300; tlo1[5] = mk(20'h60005, 2'd2, 2'd1, 1'b1, 1'b1);
    inv_req = 1'b1; inv_op = 2'd0;
    wr_en = 1'b1; wr_idx = 3'd7; wr_e = 1'b0; wr_vpn2 = tvpn[7]; wr_asid = 10'd7;
    busy_cnt = 1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        chk("busy_lkp_no_rsp", 64'(rsp_valid), 64'd0);
        inv_req = 1'b0; wr_en = 1'b0; lkp_valid = 1'b0;
      end
      if (!inv_busy) break;
      busy_cnt++;
    end
    chk("busy_cycles", 64'(busy_cnt), 64'd8);

    for (int i = 0; i < 8; i++) begin
      texp[i] = !(i == 1 || i == 2);
      look($sformatf("after_inv_idx%0d", i), tvpn[i], 1'b1, tasid[i], texp[i],
           texp[i] ? tlo1[i] : 26'd0);
    end

    // Reset dropped between clock edges while the sweep is at index 3.
    @(negedge clk);
    inv_req = 1'b1; inv_op = 2'd0;
    @(posedge clk); #1;
    inv_req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_reset_busy_ready", 64'({inv_busy, lkp_ready}), 64'b01);
    chk("async_reset_rsp", 64'(rsp_bus()), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 8; i++)
      look($sformatf("after_reset_idx%0d", i), tvpn[i], 1'b1, tasid[i], 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
